// File: rtl/keypoint_merge_reader_pkg.sv
// ============================================================================
// Module   : sift_kp_pkg
// Purpose  : Shared keypoint widths, record type, layer tags and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sift_kp_pkg;

  localparam int KP_ADDR_W = 11;
  localparam int KP_ROW_W  = 9;
  localparam int KP_COL_W  = 10;
  localparam int KP_W      = KP_ROW_W + KP_COL_W;
  localparam int KP_CNT_W  = KP_ADDR_W + 1;
  localparam int KP_TOT_W  = KP_ADDR_W + 2;

  // Row sits above column so a plain unsigned compare gives raster order
  typedef struct packed {
    logic [KP_ROW_W-1:0] row;
    logic [KP_COL_W-1:0] col;
  } kp_t;

  localparam logic [1:0] c_LAYER_L1   = 2'b01;
  localparam logic [1:0] c_LAYER_L2   = 2'b10;
  localparam logic [1:0] c_LAYER_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MERGE = 2'd2,
    ST_DONE  = 2'd3
  } kp_state_e;

endpackage

`default_nettype wire

// File: rtl/keypoint_merge_reader_if.sv
// ============================================================================
// Module   : keypoint_merge_reader_if
// Purpose  : Valid/ready stream carrying merged keypoints downstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypoint_merge_reader_if;
  import sift_kp_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [KP_W-1:0] out_data;
  logic [1:0]      out_layer;
  logic            out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_layer,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_layer,
    input  out_last,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/keypoint_merge_reader_kp_head_fetch.sv
// ============================================================================
// Module   : kp_head_fetch
// Purpose  : Streams one sorted keypoint list from a 1-cycle-latency SRAM
//            into a single head register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kp_head_fetch
  import sift_kp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 consume,
  input  logic [KP_CNT_W-1:0]  count,
  output logic [KP_ADDR_W-1:0] addr,
  input  kp_t                  dout,
  output kp_t                  head,
  output logic                 head_valid,
  output logic                 drained,
  output logic                 exhausted
);

  logic [KP_CNT_W-1:0]  r_count;
  logic [KP_CNT_W-1:0]  r_rd_idx;
  logic [KP_ADDR_W-1:0] r_addr;
  logic                 r_pending;
  logic                 r_head_valid;
  kp_t                  r_head;
  logic                 w_issue;

  assign w_issue = en && (!r_head_valid || consume) && !r_pending && (r_rd_idx < r_count);

  // Hold the last issued address so a full list never wraps back to 0
  assign addr       = w_issue ? r_rd_idx[KP_ADDR_W-1:0] : r_addr;
  assign head       = r_head;
  assign head_valid = r_head_valid;
  assign drained    = (r_rd_idx == r_count);
  assign exhausted  = drained && !r_pending && !r_head_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_rd_idx     <= '0;
      r_addr       <= '0;
      r_pending    <= 1'b0;
      r_head_valid <= 1'b0;
      r_head       <= '0;
    end else if (clr) begin
      r_count      <= count;
      r_rd_idx     <= '0;
      r_addr       <= '0;
      r_pending    <= 1'b0;
      r_head_valid <= 1'b0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_rd_idx <= r_rd_idx + 1'b1;
        r_addr   <= r_rd_idx[KP_ADDR_W-1:0];
      end
      if (r_pending) begin
        r_head       <= dout;
        r_head_valid <= 1'b1;
      end else if (consume) begin
        r_head_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypoint_merge_reader.sv
// ============================================================================
// Module   : keypoint_merge_reader
// Purpose  : Merges two raster-sorted keypoint lists into one valid/ready
//            stream. Define KP_DEDUP_EN to fold equal heads into one entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypoint_merge_reader
  import sift_kp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KP_CNT_W-1:0]  kp1_count,
  input  logic [KP_CNT_W-1:0]  kp2_count,
  output logic [KP_ADDR_W-1:0] kp1_addr,
  input  logic [KP_W-1:0]      kp1_dout,
  output logic [KP_ADDR_W-1:0] kp2_addr,
  input  logic [KP_W-1:0]      kp2_dout,
  keypoint_merge_reader_if.master out_if,
  output logic                 done,
  output logic [KP_TOT_W-1:0]  total_count
);

  kp_state_e           r_state, w_state_nxt;
  logic                w_clr, w_fetch_en, w_merge_en;
  kp_t                 w_head1, w_head2;
  logic                w_hv1, w_hv2, w_drn1, w_drn2, w_ex1, w_ex2;
  logic [KP_W-1:0]     w_key1, w_key2;
  logic                w_take1, w_take2, w_heads_rdy, w_load, w_last;
  logic [KP_W-1:0]     w_sel_data;
  logic [1:0]          w_sel_layer;
  logic                r_out_valid, r_out_last;
  logic [KP_W-1:0]     r_out_data;
  logic [1:0]          r_out_layer;
  logic [KP_TOT_W-1:0] r_total;

  kp_head_fetch u_fetch1 (
    .clk, .rst_n, .clr(w_clr), .en(w_fetch_en), .consume(w_load && w_take1),
    .count(kp1_count), .addr(kp1_addr), .dout(kp1_dout),
    .head(w_head1), .head_valid(w_hv1), .drained(w_drn1), .exhausted(w_ex1)
  );

  kp_head_fetch u_fetch2 (
    .clk, .rst_n, .clr(w_clr), .en(w_fetch_en), .consume(w_load && w_take2),
    .count(kp2_count), .addr(kp2_addr), .dout(kp2_dout),
    .head(w_head2), .head_valid(w_hv2), .drained(w_drn2), .exhausted(w_ex2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = (w_ex1 && w_ex2) ? ST_DONE : ST_MERGE;
      ST_MERGE: if (r_out_valid && r_out_last && out_if.out_ready) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_clr      = (r_state == ST_IDLE) && start;
    w_fetch_en = (r_state == ST_FETCH) || (r_state == ST_MERGE);
    w_merge_en = (r_state == ST_MERGE);
    done       = (r_state == ST_DONE);
  end

  assign w_key1 = w_head1;
  assign w_key2 = w_head2;

  // Ties go to list 1 first, or to both lists when folding duplicates
  always_comb begin
    w_take1 = 1'b0;
    w_take2 = 1'b0;
    if (w_ex2)                 w_take1 = 1'b1;
    else if (w_ex1)            w_take2 = 1'b1;
    else if (w_key1 < w_key2)  w_take1 = 1'b1;
    else if (w_key1 > w_key2)  w_take2 = 1'b1;
    else begin
`ifdef KP_DEDUP_EN
      w_take1 = 1'b1;
      w_take2 = 1'b1;
`else
      w_take1 = 1'b1;
`endif
    end
  end

  assign w_heads_rdy = (w_hv1 || w_ex1) && (w_hv2 || w_ex2) && !(w_ex1 && w_ex2);
  assign w_load      = w_merge_en && w_heads_rdy && (!r_out_valid || out_if.out_ready);
  assign w_sel_data  = w_take1 ? w_key1 : w_key2;
  assign w_sel_layer = (w_take1 && w_take2) ? c_LAYER_BOTH :
                       w_take1              ? c_LAYER_L1   : c_LAYER_L2;
  // Last when every list is empty once the selected head(s) leave
  assign w_last      = (w_take1 ? w_drn1 : w_ex1) && (w_take2 ? w_drn2 : w_ex2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_layer <= '0;
      r_out_last  <= 1'b0;
      r_total     <= '0;
    end else begin
      if (w_clr)       r_total <= '0;
      else if (w_load) r_total <= r_total + 1'b1;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_layer <= w_sel_layer;
        r_out_last  <= w_last;
      end else if (out_if.out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_if.out_valid = r_out_valid;
  assign out_if.out_data  = r_out_data;
  assign out_if.out_layer = r_out_layer;
  assign out_if.out_last  = r_out_last;
  assign total_count      = r_total;

endmodule

`default_nettype wire
